// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the two-requester register write arbiter: FSM states,
// requester indices and the round-robin winner pick.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // On a tie the requester that did not complete the last write wins.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1 ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Request/grant/ack bundle between the two writers and the arbiter.
interface reg_write_arbiter_if #(parameter int WIDTH = 8);
  logic             req0, req1;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1;
  logic             ack0, ack1;
  logic             busy;
  logic [WIDTH-1:0] Q, Qr;

  modport slave  (input  req0, req1, d0, d1,
                  output gnt0, gnt1, ack0, ack1, busy, Q, Qr);
  modport master (output req0, req1, d0, d1,
                  input  gnt0, gnt1, ack0, ack1, busy, Q, Qr);
endinterface

// File: rtl/reg_write_arbiter_dff_reg.sv
// WIDTH-bit load-enabled register with async active-low clear and a
// complemented output.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qr
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q  = r_q;
  assign o_qr = ~r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester write arbiter: IDLE->GRANT->WRITE->ACK handshake in front of
// one shared register, alternating between requesters on a tie.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               r,
  reg_write_arbiter_if.slave bus
);

  state_t           r_state;
  logic             r_owner, r_last;
  logic             r_gnt0, r_gnt1, r_ack0, r_ack1, r_busy;
  logic             w_req_own, w_winner, w_load;
  logic [WIDTH-1:0] w_d, w_q, w_qr;

  assign w_req_own = (r_owner == REQ1) ? bus.req1 : bus.req0;
  assign w_d       = (r_owner == REQ1) ? bus.d1   : bus.d0;
  assign w_winner  = pick_winner(bus.req0, bus.req1, r_last);
  // The register loads only when the owner is still requesting at WRITE exit.
  assign w_load    = (r_state == WRITE) && w_req_own;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state <= IDLE;
      r_owner <= REQ0;
      r_last  <= REQ1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_state <= GRANT;
            r_owner <= w_winner;
            r_gnt0  <= (w_winner == REQ0);
            r_gnt1  <= (w_winner == REQ1);
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (w_req_own) begin
            r_state <= WRITE;
          end else begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        WRITE: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          if (w_req_own) begin
            r_state <= ACK;
            r_last  <= r_owner;
            r_ack0  <= (r_owner == REQ0);
            r_ack1  <= (r_owner == REQ1);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ACK: begin
          if (!w_req_own) begin
            r_state <= IDLE;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_q (
    .clk    (clk),
    .rst_n  (r),
    .i_load (w_load),
    .i_d    (w_d),
    .o_q    (w_q),
    .o_qr   (w_qr)
  );

  assign bus.gnt0 = r_gnt0;
  assign bus.gnt1 = r_gnt1;
  assign bus.ack0 = r_ack0;
  assign bus.ack1 = r_ack1;
  assign bus.busy = r_busy;
  assign bus.Q    = w_q;
  assign bus.Qr   = w_qr;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: drivers push expected writes into a
// scoreboard, a negedge monitor pops and checks on every new acknowledge.
module tb_reg_write_arbiter;

  typedef struct {
    logic       who;
    logic [7:0] q;
  } exp_t;

  logic clk;
  logic r;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  reg_write_arbiter_if #(.WIDTH(8)) bus();

  reg_write_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ackv(input logic w);
    return w ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic gntv(input logic w);
    return w ? bus.gnt1 : bus.gnt0;
  endfunction

  task automatic push(input logic who, input logic [7:0] q);
    exp_t e;
    e.who = who;
    e.q   = q;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic who, input logic v);
    if (who) bus.req1 = v;
    else     bus.req0 = v;
  endtask

  task automatic wait_ack(input logic who);
    int n = 0;
    while (!ackv(who) && n < 12) begin
      tick();
      n++;
    end
    chk(who ? "ack1_wait" : "ack0_wait", ackv(who), 1);
  endtask

  // Scoreboard monitor plus per-cycle output invariants.
  initial begin
    logic       pa0, pa1;
    logic [7:0] nq;
    exp_t       e;
    pa0 = 1'b0;
    pa1 = 1'b0;
    forever begin
      @(negedge clk);
      if (r !== 1'b1) begin
        pa0 = 1'b0;
        pa1 = 1'b0;
      end else begin
        chk("exclusive", (bus.gnt0 & bus.gnt1) | (bus.ack0 & bus.ack1) |
                         (bus.gnt0 & bus.ack0) | (bus.gnt1 & bus.ack1), 0);
        chk("busy_state", bus.busy, bus.gnt0 | bus.gnt1 | bus.ack0 | bus.ack1);
        if ((bus.ack0 && !pa0) || (bus.ack1 && !pa1)) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack ack0=%0b ack1=%0b expected=none t=%0t",
                     bus.ack0, bus.ack1, $time);
          end else begin
            e  = sb.pop_front();
            nq = ~e.q;
            chk("ack_who", bus.ack1, e.who);
            chk("ack_Q",   bus.Q,    e.q);
            chk("ack_Qr",  bus.Qr,   nq);
          end
        end
        pa0 = bus.ack0;
        pa1 = bus.ack1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       who;
    logic [7:0] nv;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.d0   = 8'h00;
    bus.d1   = 8'h00;
    r = 1'b1;
    #1 r = 1'b0;
    #2;
    chk("rst_Q",    bus.Q,    8'h00);
    chk("rst_Qr",   bus.Qr,   8'hFF);
    chk("rst_gnt",  {bus.gnt1, bus.gnt0}, 0);
    chk("rst_ack",  {bus.ack1, bus.ack0}, 0);
    chk("rst_busy", bus.busy, 0);
    tick();
    tick();
    r = 1'b1;

    // Single write with exact latency.
    bus.req0 = 1'b1;
    bus.d0   = 8'h3C;
    push(1'b0, 8'h3C);
    tick();
    chk("single_gnt_n",  {bus.gnt1, bus.gnt0}, 2'b01);
    chk("single_busy",   bus.busy, 1);
    tick();
    chk("single_gnt_n1", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("single_Q_n1",   bus.Q, 8'h00);
    tick();
    chk("single_ack_n2", bus.ack0, 1);
    chk("single_gnt_n2", bus.gnt0, 0);
    chk("single_Q_n2",   bus.Q, 8'h3C);
    bus.req0 = 1'b0;
    tick();
    chk("single_idle",   bus.busy, 0);
    chk("single_ackoff", bus.ack0, 0);

    // Reset in the middle of a WRITE.
    bus.req0 = 1'b1;
    bus.d0   = 8'hA5;
    tick();
    tick();
    #2 r = 1'b0;
    #1;
    chk("midrst_Q",    bus.Q,  8'h00);
    chk("midrst_Qr",   bus.Qr, 8'hFF);
    chk("midrst_gnt",  {bus.gnt1, bus.gnt0, bus.ack1, bus.ack0}, 0);
    chk("midrst_busy", bus.busy, 0);
    bus.req0 = 1'b0;
    tick();
    r = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst_noack", bus.ack0, 0);
    chk("midrst_Qkeep", bus.Q, 8'h00);

    // Tie after reset: requester 0 first, then 1 after one IDLE cycle.
    bus.req0 = 1'b1;
    bus.d0   = 8'h11;
    bus.req1 = 1'b1;
    bus.d1   = 8'h22;
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    tick();
    chk("tie_first", {bus.gnt1, bus.gnt0}, 2'b01);
    wait_ack(1'b0);
    bus.req0 = 1'b0;
    tick();
    chk("tie_idle",  bus.busy, 0);
    tick();
    chk("tie_second", {bus.gnt1, bus.gnt0}, 2'b10);
    wait_ack(1'b1);
    bus.req1 = 1'b0;
    tick();

    // Fairness: both keep re-requesting, six writes must alternate 0,1,...
    bus.d0   = 8'h41;
    bus.d1   = 8'h81;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      who = k[0];
      push(who, who ? bus.d1 : bus.d0);
      wait_ack(who);
      chk("fair_other_gnt", gntv(~who), 0);
      set_req(who, 1'b0);
      tick();
      if (k < 4) begin
        nv = who ? 8'h90 + 8'(k) : 8'h50 + 8'(k);
        if (who) bus.d1 = nv;
        else     bus.d0 = nv;
        set_req(who, 1'b1);
      end
    end
    tick();
    chk("fair_done", bus.busy, 0);

    // Abort: requester 1 drops during WRITE, register keeps 0x12.
    bus.req0 = 1'b1;
    bus.d0   = 8'h12;
    push(1'b0, 8'h12);
    wait_ack(1'b0);
    bus.req0 = 1'b0;
    tick();
    bus.req1 = 1'b1;
    bus.d1   = 8'h77;
    tick();
    chk("abort_gnt", bus.gnt1, 1);
    tick();
    bus.req1 = 1'b0;
    tick();
    chk("abort_idle", bus.busy, 0);
    chk("abort_Q",    bus.Q, 8'h12);
    chk("abort_ack",  bus.ack1, 0);
    tick();
    chk("abort_ack2", bus.ack1, 0);

    // Ack hold: ack0 stays while req0 is held, req1 waits.
    bus.req0 = 1'b1;
    bus.d0   = 8'h5A;
    push(1'b0, 8'h5A);
    wait_ack(1'b0);
    bus.req1 = 1'b1;
    bus.d1   = 8'h6B;
    push(1'b1, 8'h6B);
    for (int i = 0; i < 4; i++) begin
      chk("hold_ack0", bus.ack0, 1);
      chk("hold_gnt1", bus.gnt1, 0);
      tick();
    end
    bus.req0 = 1'b0;
    tick();
    chk("hold_release", {bus.ack0, bus.gnt1}, 0);
    tick();
    chk("hold_gnt1_next", bus.gnt1, 1);
    wait_ack(1'b1);
    bus.req1 = 1'b0;
    tick();
    tick();
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register.
REQ-002 clk  input  1  rising-edge clock for all state and the register.
REQ-003 r  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  write request, requester 0; held until ack0.
REQ-005 d0  input  WIDTH  write data, requester 0; stable while req0 high.
REQ-006 req1  input  1  write request, requester 1; held until ack1.
REQ-007 d1  input  WIDTH  write data, requester 1; stable while req1 high.
REQ-008 gnt0, gnt1  output  1 each  grant; one-hot or zero.
REQ-009 ack0, ack1  output  1 each  write-complete acknowledge.
REQ-010 Q  output  WIDTH  shared register contents.
REQ-011 Qr  output  WIDTH  bitwise complement of Q, always.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, WRITE, ACK; all transitions on rising clk.
REQ-014 IDLE: no req -> stay; any req -> GRANT, latching winner into register "owner".
REQ-015 Winner: single requester wins; both high -> requester not equal to "last" wins.
REQ-016 "last" SHALL update to owner on entry to ACK only (completed writes only).
REQ-017 GRANT: gnt[owner]=1 for the cycle; req[owner] high -> WRITE, low -> IDLE (abort, no write).
REQ-018 WRITE: gnt[owner]=1; at exit edge, req[owner] high -> Q<=d[owner], go ACK; low -> IDLE, Q unchanged.
REQ-019 ACK: ack[owner]=1, gnt deasserted; stay until req[owner] low, then IDLE.
REQ-020 Latency: req sampled at edge n in IDLE -> gnt high after n, Q updated and ack high after edge n+2.
REQ-021 Non-owner request SHALL be held pending, never dropped or granted, until IDLE is re-entered.
REQ-022 gnt0&gnt1, ack0&ack1, and gnt&ack for the same requester SHALL never be high together.
REQ-023 Q SHALL change only at the WRITE exit edge or on reset.
REQ-024 Back-to-back: ACK->IDLE with other req pending SHALL take GRANT next cycle (one IDLE cycle).

Reset
REQ-025 r low SHALL immediately force: state IDLE, Q=0, Qr=all ones, gnt=0, ack=0, busy=0, last=1, owner=0.
REQ-026 Reset mid-operation SHALL discard any in-flight write; no ack issued for it.
REQ-027 First edge after r rises SHALL evaluate IDLE normally.

Structure
REQ-028 Shared package SHALL hold the state enumeration (IDLE=0, GRANT=1, WRITE=2, ACK=3) and requester index constants.
REQ-029 Shared register SHALL be a sub-module dff_reg (WIDTH D flip-flops, load enable, async active-low reset, Q/Qr outputs).
REQ-030 Arbitration and FSM SHALL live in reg_write_arbiter; no combinational path from req to Q.

Verification
REQ-031 Reset: r=0 mid-WRITE with d0=0xA5 -> Q=0x00, Qr=0xFF, gnt/ack=0 immediately; no ack0 after release.
REQ-032 Single: req0=1, d0=0x3C at edge n -> gnt0 after n, Q=0x3C and ack0 after n+2; req0 low -> IDLE next edge.
REQ-033 Tie after reset: req0=req1=1 -> requester 0 first (Q=d0), then requester 1 (Q=d1) without req1 dropping.
REQ-034 Fairness: both held continuously, 6 writes -> grants alternate 0,1,0,1,0,1.
REQ-035 Abort: req1 drops during WRITE, d1=0x77, Q=0x12 -> Q stays 0x12, no ack1, IDLE next edge.
REQ-036 Ack hold: req0 held 4 cycles past ack0 -> ack0 stays high 4 cycles, req1 ungranted until req0 low.
